// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: state codes,
// RV32I major opcodes, datapath mux-select codes and the control bundle.
package multicycle_ctrl_fsm_pkg;

  // FSM state encodings (all 16 codes of the 4-bit register are used)
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WRITE = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_LUI       = 4'd8;
  localparam logic [3:0] S_AUIPC     = 4'd9;
  localparam logic [3:0] S_ALU_WB    = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JAL       = 4'd12;
  localparam logic [3:0] S_JALR_ADDR = 4'd13;
  localparam logic [3:0] S_JALR_PC   = 4'd14;
  localparam logic [3:0] S_FAULT     = 4'd15;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Every control output of the FSM, grouped so one default clears them all
  typedef struct packed {
    logic       mem_req;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       fault;
  } ctrl_t;

  // States that wait on the memory handshake and are guarded by the timeout
  function automatic logic is_mem_wait(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_branch_cond_unit.sv
// Branch condition evaluation: maps funct3 and the rs1-rs2 ALU flags to a
// taken decision, and flags the two funct3 codes RV32I leaves unassigned.
module branch_cond_unit (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken,
  output logic       illegal
);

  // Decode funct3 into the taken decision for BEQ/BNE/BLT/BGE/BLTU/BGEU
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control FSM driving a shared-memory datapath
// (PC/OldPC/IR/ALUOut/Data). Memory accesses use a mem_ready handshake with a
// timeout into a sticky FAULT state; instr_done pulses as each instruction retires.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 15,
  parameter int TO_W         = 4,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       fault
);

  logic [3:0]      state;
  logic [3:0]      next_state;
  logic [TO_W-1:0] to_cnt;
  logic            br_taken;
  logic            br_illegal;
  logic            timeout_hit;
  ctrl_t           ctrl;

  // funct7 is decoded by the downstream ALU decoder, not by this FSM
  logic unused_funct7;
  assign unused_funct7 = ^funct7;

  branch_cond_unit u_branch_cond (
    .funct3  (funct3),
    .zero    (zero),
    .lt      (lt),
    .ltu     (ltu),
    .taken   (br_taken),
    .illegal (br_illegal)
  );

  // Last permitted waiting cycle expired without mem_ready; a late ready still wins
  assign timeout_hit = is_mem_wait(state) && !mem_ready
                       && (to_cnt == TO_W'(MEM_TIMEOUT - 1));

  // Next-state selection; a timeout overrides the normal flow
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:     if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEM_ADDR;
          OP_R:              next_state = S_EXEC_R;
          OP_I_ALU:          next_state = S_EXEC_I;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR_ADDR;
          OP_LUI:            next_state = S_LUI;
          OP_AUIPC:          next_state = S_AUIPC;
          default:           next_state = (ILLEGAL_TRAP != 0) ? S_FAULT : S_FETCH;
        endcase
      end
      S_MEM_ADDR:  next_state = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) next_state = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) next_state = S_FETCH;
      S_MEM_WB:    next_state = S_FETCH;
      S_EXEC_R,
      S_EXEC_I,
      S_LUI,
      S_AUIPC:     next_state = S_ALU_WB;
      S_ALU_WB:    next_state = S_FETCH;
      S_BRANCH:    next_state = ((ILLEGAL_TRAP != 0) && br_illegal) ? S_FAULT : S_FETCH;
      S_JAL:       next_state = S_ALU_WB;
      S_JALR_ADDR: next_state = S_JALR_PC;
      S_JALR_PC:   next_state = S_ALU_WB;
      S_FAULT:     next_state = S_FAULT;
      default:     next_state = S_FAULT;
    endcase
    if (timeout_hit) next_state = S_FAULT;
  end

  // State register; rst returns to FETCH at once
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // Timeout counter: counts stalled cycles in a wait state, zero everywhere else,
  // so it is already clear on entry to FETCH/MEM_READ/MEM_WRITE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          to_cnt <= '0;
    else if (is_mem_wait(state) && next_state == state) to_cnt <= to_cnt + TO_W'(1);
    else                                              to_cnt <= '0;
  end

  // Control decode: Moore per state, with PCWrite/IRWrite/instr_done qualified
  // where the handshake or branch outcome decides; everything drops during rst
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_req    = 1'b1;
          ctrl.adr_src    = 1'b0;
          ctrl.alu_src_a  = SRCA_PC;
          ctrl.alu_src_b  = SRCB_FOUR;
          ctrl.alu_op     = ALUOP_ADD;
          ctrl.result_src = RES_ALURESULT;
          ctrl.ir_write   = mem_ready;
          ctrl.pc_write   = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_a = SRCA_OLDPC;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEM_ADDR, S_JALR_ADDR: begin
          ctrl.alu_src_a = SRCA_RS1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEM_READ: begin
          ctrl.mem_req    = 1'b1;
          ctrl.adr_src    = 1'b1;
          ctrl.result_src = RES_ALUOUT;
        end
        S_MEM_WRITE: begin
          ctrl.mem_req    = 1'b1;
          ctrl.adr_src    = 1'b1;
          ctrl.result_src = RES_ALUOUT;
          ctrl.mem_write  = 1'b1;
          ctrl.instr_done = mem_ready;
        end
        S_MEM_WB: begin
          ctrl.result_src = RES_DATA;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_EXEC_R: begin
          ctrl.alu_src_a = SRCA_RS1;
          ctrl.alu_src_b = SRCB_RS2;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_EXEC_I: begin
          ctrl.alu_src_a = SRCA_RS1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_LUI: begin
          ctrl.alu_src_a = SRCA_ZERO;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_AUIPC: begin
          ctrl.alu_src_a = SRCA_OLDPC;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_ALU_WB: begin
          ctrl.result_src = RES_ALUOUT;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a  = SRCA_RS1;
          ctrl.alu_src_b  = SRCB_RS2;
          ctrl.alu_op     = ALUOP_SUB;
          ctrl.result_src = RES_ALUOUT;
          ctrl.pc_write   = br_taken;
          // An illegal branch that traps does not retire
          ctrl.instr_done = !((ILLEGAL_TRAP != 0) && br_illegal);
        end
        S_JAL, S_JALR_PC: begin
          ctrl.alu_src_a  = SRCA_OLDPC;
          ctrl.alu_src_b  = SRCB_FOUR;
          ctrl.alu_op     = ALUOP_ADD;
          ctrl.result_src = RES_ALUOUT;
          ctrl.pc_write   = 1'b1;
        end
        S_FAULT:  ctrl.fault = 1'b1;
        default:  ctrl.fault = 1'b1;
      endcase
    end
  end

  assign mem_req    = ctrl.mem_req;
  assign PCWrite    = ctrl.pc_write;
  assign AdrSrc     = ctrl.adr_src;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign RegWrite   = ctrl.reg_write;
  assign ResultSrc  = ctrl.result_src;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign instr_done = ctrl.instr_done;
  assign fault      = ctrl.fault;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed, self-checking bench for multicycle_ctrl_fsm. Each step drives one
// clock cycle of inputs, queues the expected output vector, and compares it
// against the DUT mid-cycle (on the falling edge).
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, lt, ltu, mem_ready;
  logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, alu_op;
  logic       instr_done, fault;

  int total = 0;
  int bad   = 0;

  // RV32I opcodes as used by the stimulus
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] RTYP  = 7'b0110011;
  localparam logic [6:0] BRNCH = 7'b1100011;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BADOP = 7'b1111111;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];

  multicycle_ctrl_fsm #(
    .MEM_TIMEOUT  (15),
    .TO_W         (4),
    .ILLEGAL_TRAP (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  wire [15:0] obs = {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                     ResultSrc, ALUSrcA, ALUSrcB, alu_op, instr_done, fault};

  // Packs one expected output vector in the same order as obs
  function automatic logic [15:0] mk(input bit req, pcw, adr, mw, irw, rw,
                                     input bit [1:0] res, a, b, op,
                                     input bit done, flt);
    return {req, pcw, adr, mw, irw, rw, res, a, b, op, done, flt};
  endfunction

  function automatic logic [15:0] e_fetch(input bit mr);
    return mk(1, mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
  endfunction
  function automatic logic [15:0] e_mem_write(input bit mr);
    return mk(1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, mr, 0);
  endfunction
  function automatic logic [15:0] e_branch(input bit t);
    return mk(0, t, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 1, 0);
  endfunction

  localparam logic [15:0] E_ZERO = 16'h0000;
  localparam logic [15:0] E_FAULT = 16'h0001;
  wire [15:0] e_decode    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0);
  wire [15:0] e_rs1_imm   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0);
  wire [15:0] e_mem_read  = mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
  wire [15:0] e_mem_wb    = mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0);
  wire [15:0] e_exec_r    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
  wire [15:0] e_alu_wb    = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
  wire [15:0] e_jalr_pc   = mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0);

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // One clock cycle: called just after a rising edge, drives inputs, queues the
  // expectation, compares on the falling edge, returns just after the next rise
  task automatic cyc(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic z, l, lu, mr, input logic [15:0] want);
    exp_t e;
    opcode = op; funct3 = f3; zero = z; lt = l; ltu = lu; mem_ready = mr;
    e.tag = tag;
    e.v   = want;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check(e.tag, obs, e.v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc("in_reset", RTYP, 3'b000, 0, 0, 0, 1, E_ZERO);
    rst = 1'b0;

    // R-type with an immediate fetch
    cyc("fetch_rdy",   RTYP, 3'b000, 0, 0, 0, 1, e_fetch(1));
    cyc("decode_r",    RTYP, 3'b000, 0, 0, 0, 0, e_decode);
    cyc("exec_r",      RTYP, 3'b000, 0, 0, 0, 0, e_exec_r);
    cyc("alu_wb_r",    RTYP, 3'b000, 0, 0, 0, 0, e_alu_wb);

    // Fetch stalls three cycles, then LW with a 2-cycle memory delay
    for (int i = 0; i < 3; i++)
      cyc($sformatf("fetch_stall%0d", i), LOAD, 3'b010, 0, 0, 0, 0, e_fetch(0));
    cyc("fetch_late",  LOAD, 3'b010, 0, 0, 0, 1, e_fetch(1));
    cyc("decode_lw",   LOAD, 3'b010, 0, 0, 0, 0, e_decode);
    cyc("mem_addr_lw", LOAD, 3'b010, 0, 0, 0, 0, e_rs1_imm);
    cyc("mem_read0",   LOAD, 3'b010, 0, 0, 0, 0, e_mem_read);
    cyc("mem_read1",   LOAD, 3'b010, 0, 0, 0, 0, e_mem_read);
    cyc("mem_read2",   LOAD, 3'b010, 0, 0, 0, 1, e_mem_read);
    cyc("mem_wb",      LOAD, 3'b010, 0, 0, 0, 0, e_mem_wb);

    // BGE with lt=0: taken
    cyc("fetch_bge",   BRNCH, 3'b101, 0, 0, 1, 1, e_fetch(1));
    cyc("decode_bge",  BRNCH, 3'b101, 0, 0, 1, 0, e_decode);
    cyc("branch_bge",  BRNCH, 3'b101, 0, 0, 1, 0, e_branch(1));

    // BLTU with ltu=0: not taken
    cyc("fetch_bltu",  BRNCH, 3'b110, 1, 1, 0, 1, e_fetch(1));
    cyc("decode_bltu", BRNCH, 3'b110, 1, 1, 0, 0, e_decode);
    cyc("branch_bltu", BRNCH, 3'b110, 1, 1, 0, 0, e_branch(0));

    // JALR through both address phases and the link write-back
    cyc("fetch_jalr",  JALR, 3'b000, 0, 0, 0, 1, e_fetch(1));
    cyc("decode_jalr", JALR, 3'b000, 0, 0, 0, 0, e_decode);
    cyc("jalr_addr",   JALR, 3'b000, 0, 0, 0, 0, e_rs1_imm);
    cyc("jalr_pc",     JALR, 3'b000, 0, 0, 0, 0, e_jalr_pc);
    cyc("alu_wb_jalr", JALR, 3'b000, 0, 0, 0, 0, e_alu_wb);

    // Store: MemWrite held while waiting, instr_done only with mem_ready
    cyc("fetch_sw",    STORE, 3'b010, 0, 0, 0, 1, e_fetch(1));
    cyc("decode_sw",   STORE, 3'b010, 0, 0, 0, 0, e_decode);
    cyc("mem_addr_sw", STORE, 3'b010, 0, 0, 0, 0, e_rs1_imm);
    cyc("mem_write0",  STORE, 3'b010, 0, 0, 0, 0, e_mem_write(0));
    cyc("mem_write1",  STORE, 3'b010, 0, 0, 0, 1, e_mem_write(1));

    // LW whose ready arrives on the last allowed cycle: ready wins over timeout
    cyc("fetch_lw2",   LOAD, 3'b010, 0, 0, 0, 1, e_fetch(1));
    cyc("decode_lw2",  LOAD, 3'b010, 0, 0, 0, 0, e_decode);
    cyc("mem_addr_lw2", LOAD, 3'b010, 0, 0, 0, 0, e_rs1_imm);
    for (int i = 1; i <= 14; i++)
      cyc($sformatf("rd_wait%0d", i), LOAD, 3'b010, 0, 0, 0, 0, e_mem_read);
    cyc("rd_wait15_rdy", LOAD, 3'b010, 0, 0, 0, 1, e_mem_read);
    cyc("mem_wb2",     LOAD, 3'b010, 0, 0, 0, 0, e_mem_wb);

    // Unknown opcode traps; fault is sticky until rst
    cyc("fetch_bad",   BADOP, 3'b000, 0, 0, 0, 1, e_fetch(1));
    cyc("decode_bad",  BADOP, 3'b000, 0, 0, 0, 1, e_decode);
    cyc("fault_ill0",  BADOP, 3'b000, 0, 0, 0, 1, E_FAULT);
    cyc("fault_ill1",  RTYP,  3'b000, 0, 0, 0, 1, E_FAULT);
    rst = 1'b1;
    cyc("rst_fault",   RTYP, 3'b000, 0, 0, 0, 1, E_ZERO);
    rst = 1'b0;

    // mem_ready stuck low in FETCH: 15 waiting cycles, fault on the 16th
    for (int i = 1; i <= 15; i++)
      cyc($sformatf("to_wait%0d", i), RTYP, 3'b000, 0, 0, 0, 0, e_fetch(0));
    cyc("to_fault16",  RTYP, 3'b000, 0, 0, 0, 0, E_FAULT);
    cyc("to_fault17",  RTYP, 3'b000, 0, 0, 0, 1, E_FAULT);
    rst = 1'b1;
    cyc("rst_to",      RTYP, 3'b000, 0, 0, 0, 1, E_ZERO);
    rst = 1'b0;
    cyc("fetch_after", RTYP, 3'b000, 0, 0, 0, 1, e_fetch(1));
    cyc("decode_after", RTYP, 3'b000, 0, 0, 0, 0, e_decode);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
